// File: rtl/v_chunk_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : v_chunk_arbiter_if
// Brief    : Bundle of requester and UART TX byte signals around the
//            chunk arbiter. The arbiter uses the slave side; the requesters
//            and the transmitter (or a bench) use the master side.
// Revision : 1.0 - initial release
// ============================================================================
interface v_chunk_arbiter_if #(
  parameter int NUM_REQUESTERS      = 4,
  parameter int CHUNK_PAYLOAD_BYTES = 2,
  parameter int GRANT_INDEX_SIZE    = 2
);
  logic [NUM_REQUESTERS-1:0]                       req_should_update;
  logic [NUM_REQUESTERS*8-1:0]                     req_tx_chunk_type;
  logic [NUM_REQUESTERS*CHUNK_PAYLOAD_BYTES*8-1:0] req_tx_chunk_bytes;
  logic [NUM_REQUESTERS-1:0]                       req_reset;
  logic [7:0]                                      tx_byte;
  logic                                            tx_valid;
  logic                                            tx_ready;
  logic                                            busy;
  logic [GRANT_INDEX_SIZE-1:0]                     grant_index;

  // Requesters and UART transmitter side
  modport master (
    output req_should_update, req_tx_chunk_type, req_tx_chunk_bytes, tx_ready,
    input  req_reset, tx_byte, tx_valid, busy, grant_index
  );

  // Arbiter side
  modport slave (
    input  req_should_update, req_tx_chunk_type, req_tx_chunk_bytes, tx_ready,
    output req_reset, tx_byte, tx_valid, busy, grant_index
  );
endinterface
`default_nettype wire

// File: rtl/v_chunk_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : v_chunk_arbiter
// Brief    : Round-robin arbiter sharing one UART TX byte channel between
//            virtual peripherals. A granted chunk goes out as type byte then
//            payload bytes (LSB first), then the requester gets a one-cycle
//            ack on req_reset.
// Revision : 1.0 - initial release
// ============================================================================
module v_chunk_arbiter #(
  parameter int NUM_REQUESTERS      = 4,
  parameter int CHUNK_PAYLOAD_BYTES = 2,
  parameter int GRANT_INDEX_SIZE    = 2
) (
  input logic              CLK,
  input logic              RST_N,
  v_chunk_arbiter_if.slave bus
);

  localparam int c_payload_w = CHUNK_PAYLOAD_BYTES * 8;
  localparam int c_cnt_w     = (CHUNK_PAYLOAD_BYTES > 1) ? $clog2(CHUNK_PAYLOAD_BYTES) : 1;
  localparam logic [c_cnt_w-1:0]          c_last_byte = c_cnt_w'(CHUNK_PAYLOAD_BYTES - 1);
  localparam logic [GRANT_INDEX_SIZE-1:0] c_last_req  = GRANT_INDEX_SIZE'(NUM_REQUESTERS - 1);

  typedef enum logic [1:0] {
    S_IDLE         = 2'd0,
    S_SEND_TYPE    = 2'd1,
    S_SEND_PAYLOAD = 2'd2,
    S_ACK          = 2'd3
  } state_t;

  state_t                      state_q, state_d;
  logic [GRANT_INDEX_SIZE-1:0] rr_base_q, rr_base_d;
  logic [GRANT_INDEX_SIZE-1:0] grant_index_q, grant_index_d;
  logic [7:0]                  type_q, type_d;
  logic [c_payload_w-1:0]      payload_q, payload_d;
  logic [c_cnt_w-1:0]          cnt_q, cnt_d;
  logic                        tx_valid_q, tx_valid_d;
  logic [7:0]                  tx_byte_q, tx_byte_d;
  logic [NUM_REQUESTERS-1:0]   req_reset_q, req_reset_d;
  logic                        busy_q, busy_d;

  logic                        w_found;
  logic [GRANT_INDEX_SIZE-1:0] w_pick;
  logic [7:0]                  w_sel_type;
  logic [c_payload_w-1:0]      w_sel_payload;
  logic [NUM_REQUESTERS-1:0]   w_ack_vec;

  // Payload byte idx of a latched chunk, byte 0 being the least significant
  function automatic logic [7:0] payload_byte(input logic [c_payload_w-1:0] p,
                                              input logic [c_cnt_w-1:0]     idx);
    payload_byte = 8'h00;
    for (int j = 0; j < CHUNK_PAYLOAD_BYTES; j++) begin
      if (idx == c_cnt_w'(j)) payload_byte = p[j*8 +: 8];
    end
  endfunction

  // Round-robin search: first pending request at or above rr_base_q, wrapping;
  // walking the offsets downward lets the smallest offset win
  always_comb begin : p_pick
    int cand;
    w_found = 1'b0;
    w_pick  = '0;
    cand    = 0;
    for (int k = NUM_REQUESTERS - 1; k >= 0; k--) begin
      cand = int'(rr_base_q) + k;
      if (cand >= NUM_REQUESTERS) cand = cand - NUM_REQUESTERS;
      if (bus.req_should_update[cand[GRANT_INDEX_SIZE-1:0]]) begin
        w_found = 1'b1;
        w_pick  = cand[GRANT_INDEX_SIZE-1:0];
      end
    end
  end

  // Pick out the winning requester's type/payload and build the ack one-hot
  always_comb begin
    w_sel_type    = 8'h00;
    w_sel_payload = '0;
    w_ack_vec     = '0;
    for (int i = 0; i < NUM_REQUESTERS; i++) begin
      if (w_pick == GRANT_INDEX_SIZE'(i)) begin
        w_sel_type    = bus.req_tx_chunk_type[i*8 +: 8];
        w_sel_payload = bus.req_tx_chunk_bytes[i*c_payload_w +: c_payload_w];
      end
      w_ack_vec[i] = (grant_index_q == GRANT_INDEX_SIZE'(i));
    end
  end

  // Next-state and next-output computation; all outputs come straight from flops
  always_comb begin
    state_d       = state_q;
    rr_base_d     = rr_base_q;
    grant_index_d = grant_index_q;
    type_d        = type_q;
    payload_d     = payload_q;
    cnt_d         = cnt_q;
    tx_valid_d    = tx_valid_q;
    tx_byte_d     = tx_byte_q;
    req_reset_d   = '0;
    case (state_q)
      S_IDLE: begin
        if (w_found) begin
          state_d       = S_SEND_TYPE;
          grant_index_d = w_pick;
          rr_base_d     = (w_pick == c_last_req) ? '0 : w_pick + 1'b1;
          type_d        = w_sel_type;
          payload_d     = w_sel_payload;
          tx_valid_d    = 1'b1;
          tx_byte_d     = w_sel_type;
        end
      end
      S_SEND_TYPE: begin
        if (bus.tx_ready) begin
          state_d   = S_SEND_PAYLOAD;
          cnt_d     = '0;
          tx_byte_d = payload_byte(payload_q, '0);
        end
      end
      S_SEND_PAYLOAD: begin
        if (bus.tx_ready) begin
          if (cnt_q == c_last_byte) begin
            state_d     = S_ACK;
            tx_valid_d  = 1'b0;
            tx_byte_d   = 8'h00;
            req_reset_d = w_ack_vec;
          end else begin
            cnt_d     = cnt_q + 1'b1;
            tx_byte_d = payload_byte(payload_q, cnt_q + 1'b1);
          end
        end
      end
      S_ACK: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d    = S_IDLE;
        tx_valid_d = 1'b0;
        tx_byte_d  = 8'h00;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers; async reset abandons any frame in flight
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q       <= S_IDLE;
      rr_base_q     <= '0;
      grant_index_q <= '0;
      type_q        <= 8'h00;
      payload_q     <= '0;
      cnt_q         <= '0;
      tx_valid_q    <= 1'b0;
      tx_byte_q     <= 8'h00;
      req_reset_q   <= '0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      rr_base_q     <= rr_base_d;
      grant_index_q <= grant_index_d;
      type_q        <= type_d;
      payload_q     <= payload_d;
      cnt_q         <= cnt_d;
      tx_valid_q    <= tx_valid_d;
      tx_byte_q     <= tx_byte_d;
      req_reset_q   <= req_reset_d;
      busy_q        <= busy_d;
    end
  end

  assign bus.req_reset   = req_reset_q;
  assign bus.tx_byte     = tx_byte_q;
  assign bus.tx_valid    = tx_valid_q;
  assign bus.busy        = busy_q;
  assign bus.grant_index = grant_index_q;

endmodule
`default_nettype wire

// File: tb/tb_v_chunk_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_v_chunk_arbiter
// Brief    : Scoreboard bench for v_chunk_arbiter. Expected bytes and acks
//            are queued as requests are raised and popped as the arbiter
//            transfers bytes and pulses req_reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_v_chunk_arbiter;

  logic clk;
  logic rst_n;

  v_chunk_arbiter_if #(
    .NUM_REQUESTERS(4), .CHUNK_PAYLOAD_BYTES(2), .GRANT_INDEX_SIZE(2)
  ) bus ();

  v_chunk_arbiter #(
    .NUM_REQUESTERS(4), .CHUNK_PAYLOAD_BYTES(2), .GRANT_INDEX_SIZE(2)
  ) u_dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         total = 0;
  int         bad   = 0;
  logic [7:0] exp_bytes[$];
  int         exp_acks[$];
  int         rem[4];
  logic [3:0] ack_seen;
  int         cycle    = 0;
  int         last_ack = 0;
  int         t0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: observe on the falling edge, then let requesters drop on ack
  task automatic step();
    @(negedge clk);
    cycle++;
    ack_seen = '0;
    if (bus.tx_valid) begin
      if (exp_bytes.size() == 0)
        check("unexpected_byte", 32'(bus.tx_byte), 32'hFFFF_FFFF);
      else if (bus.tx_ready)
        check("tx_byte", 32'(bus.tx_byte), 32'(exp_bytes.pop_front()));
      else
        check("stall_hold", 32'(bus.tx_byte), 32'(exp_bytes[0]));
    end
    if (bus.req_reset != '0) begin
      ack_seen = bus.req_reset;
      last_ack = cycle;
      if (exp_acks.size() == 0)
        check("unexpected_ack", 32'(bus.req_reset), 32'h0);
      else
        check("ack", 32'(bus.req_reset), 32'(1) << exp_acks.pop_front());
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      if (ack_seen[i]) begin
        rem[i]--;
        if (rem[i] <= 0) bus.req_should_update[i] = 1'b0;
      end
    end
  endtask

  task automatic raise(input int idx, input logic [7:0] t, input logic [15:0] p, input int acks);
    bus.req_tx_chunk_type[idx*8 +: 8]    = t;
    bus.req_tx_chunk_bytes[idx*16 +: 16] = p;
    bus.req_should_update[idx]           = 1'b1;
    rem[idx]                             = acks;
  endtask

  task automatic expect_frame(input int idx, input logic [7:0] t, input logic [15:0] p);
    exp_bytes.push_back(t);
    exp_bytes.push_back(p[7:0]);
    exp_bytes.push_back(p[15:8]);
    exp_acks.push_back(idx);
  endtask

  task automatic drain(input int limit);
    int n;
    n = 0;
    while ((exp_bytes.size() != 0 || exp_acks.size() != 0 || bus.busy) && n < limit) begin
      step();
      n++;
    end
    if (n >= limit) check("drain_timeout", 32'(n), 32'(limit - 1));
  endtask

  initial begin
    rst_n                  = 1'b0;
    bus.tx_ready           = 1'b1;
    bus.req_should_update  = '0;
    bus.req_tx_chunk_type  = '0;
    bus.req_tx_chunk_bytes = '0;
    for (int i = 0; i < 4; i++) rem[i] = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_tx_valid", 32'(bus.tx_valid), 32'h0);
    check("rst_tx_byte", 32'(bus.tx_byte), 32'h0);
    check("rst_busy", 32'(bus.busy), 32'h0);
    check("rst_req_reset", 32'(bus.req_reset), 32'h0);
    check("rst_grant", 32'(bus.grant_index), 32'h0);
    rst_n = 1'b1;

    // Single request, no stall
    raise(2, 8'h06, 16'hA53C, 1);
    expect_frame(2, 8'h06, 16'hA53C);
    t0 = cycle;
    step();
    step();
    check("single_busy", 32'(bus.busy), 32'h1);
    check("single_grant", 32'(bus.grant_index), 32'h2);
    drain(50);
    check("single_ack_latency", 32'(last_ack - t0), 32'd5);
    check("single_busy_after", 32'(bus.busy), 32'h0);

    // Round-robin from a fresh pointer, then wrap from 3 back to 0
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    raise(0, 8'h01, 16'h1234, 1);
    raise(3, 8'h04, 16'h5678, 1);
    expect_frame(0, 8'h01, 16'h1234);
    expect_frame(3, 8'h04, 16'h5678);
    drain(50);
    check("rr_grant_last", 32'(bus.grant_index), 32'h3);
    raise(0, 8'h01, 16'h9ABC, 1);
    raise(3, 8'h04, 16'hDEF0, 1);
    expect_frame(0, 8'h01, 16'h9ABC);
    expect_frame(3, 8'h04, 16'hDEF0);
    drain(50);
    check("rr_wrap_grant", 32'(bus.grant_index), 32'h3);

    // Starvation: req 1 keeps asking for three frames, req 2 asks once
    raise(1, 8'h02, 16'h2211, 3);
    raise(2, 8'h03, 16'h3322, 1);
    expect_frame(1, 8'h02, 16'h2211);
    expect_frame(2, 8'h03, 16'h3322);
    expect_frame(1, 8'h02, 16'h2211);
    expect_frame(1, 8'h02, 16'h2211);
    drain(100);
    check("starve_last_grant", 32'(bus.grant_index), 32'h1);

    // Backpressure on payload byte 0 for seven cycles
    raise(2, 8'h06, 16'hA53C, 1);
    expect_frame(2, 8'h06, 16'hA53C);
    t0 = cycle;
    step();
    step();
    bus.tx_ready = 1'b0;
    repeat (7) begin
      step();
      check("stall_valid", 32'(bus.tx_valid), 32'h1);
    end
    bus.tx_ready = 1'b1;
    drain(50);
    check("stall_ack_latency", 32'(last_ack - t0), 32'd12);

    // Payload input changes once the frame is granted
    raise(1, 8'h09, 16'h1111, 1);
    expect_frame(1, 8'h09, 16'h1111);
    step();
    bus.req_tx_chunk_bytes[16 +: 16] = 16'h2222;
    drain(50);

    // Reset in the middle of the payload, then a full restart
    raise(3, 8'h0C, 16'hBEEF, 1);
    expect_frame(3, 8'h0C, 16'hBEEF);
    step();
    step();
    check("mid_valid_before", 32'(bus.tx_valid), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(bus.tx_valid), 32'h0);
    check("mid_rst_req_reset", 32'(bus.req_reset), 32'h0);
    check("mid_rst_busy", 32'(bus.busy), 32'h0);
    exp_bytes.delete();
    exp_acks.delete();
    expect_frame(3, 8'h0C, 16'hBEEF);
    step();
    step();
    rst_n = 1'b1;
    drain(50);
    check("mid_regrant", 32'(bus.grant_index), 32'h3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
